// File: rtl/wb_test_status_pkg.sv
// Shared constants and types for the Wishbone test-status slave:
// register map, CONTROL/STATUS bit positions and the verdict state.
package wb_test_status_pkg;

  localparam logic [7:0] REG_EXPECTED   = 8'h00;
  localparam logic [7:0] REG_MEASURED   = 8'h04;
  localparam logic [7:0] REG_STATUS     = 8'h08;
  localparam logic [7:0] REG_FAIL_COUNT = 8'h0C;
  localparam logic [7:0] REG_FIRST_FAIL = 8'h10;
  localparam logic [7:0] REG_CONTROL    = 8'h14;

  localparam int unsigned CTRL_DONE  = 0;
  localparam int unsigned CTRL_CLEAR = 1;
  localparam int unsigned CTRL_ABORT = 2;

  localparam int unsigned STAT_LAST_FAIL = 16;
  localparam int unsigned STAT_DONE      = 17;
  localparam int unsigned STAT_PASSED    = 18;
  localparam int unsigned STAT_FAILED    = 19;

  localparam logic [15:0] FIRST_FAIL_NONE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } verdict_t;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_test_status_slave_counter.sv
// Test/fail bookkeeping: counts compare strobes, tracks mismatches,
// the first failing index and the most recent result; counters saturate.
module test_result_counter
  import wb_test_status_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   cmp_stb,
  input  logic [31:0]            expected,
  input  logic [31:0]            measured,
  output logic [COUNT_WIDTH-1:0] test_count,
  output logic [COUNT_WIDTH-1:0] fail_count,
  output logic [15:0]            first_fail,
  output logic                   last_fail
);

  logic mismatch;
  assign mismatch = (expected != measured);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_count <= '0;
      fail_count <= '0;
      first_fail <= FIRST_FAIL_NONE;
      last_fail  <= 1'b0;
    end else if (clear) begin
      test_count <= '0;
      fail_count <= '0;
      first_fail <= FIRST_FAIL_NONE;
      last_fail  <= 1'b0;
    end else if (cmp_stb) begin
      if (test_count != '1) test_count <= test_count + COUNT_WIDTH'(1);
      last_fail <= mismatch;
      if (mismatch) begin
        if (fail_count != '1) fail_count <= fail_count + COUNT_WIDTH'(1);
        // index recorded is the count before this compare was added
        if (first_fail == FIRST_FAIL_NONE) first_fail <= 16'(test_count);
      end
    end
  end

endmodule

// File: rtl/wb_test_status_slave.sv
// Wishbone classic slave collecting expected/measured pairs and driving
// sticky pass/fail verdicts; one wait state per access.
module wb_test_status_slave
  import wb_test_status_pkg::*;
#(
  parameter int unsigned NUMBER_OF_TESTS = 16,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  test_passed,
  output logic                  test_failed
);

  localparam logic [ADDR_WIDTH-3:0] W_EXPECTED   = (ADDR_WIDTH-2)'(REG_EXPECTED >> 2);
  localparam logic [ADDR_WIDTH-3:0] W_MEASURED   = (ADDR_WIDTH-2)'(REG_MEASURED >> 2);
  localparam logic [ADDR_WIDTH-3:0] W_STATUS     = (ADDR_WIDTH-2)'(REG_STATUS >> 2);
  localparam logic [ADDR_WIDTH-3:0] W_FAIL_COUNT = (ADDR_WIDTH-2)'(REG_FAIL_COUNT >> 2);
  localparam logic [ADDR_WIDTH-3:0] W_FIRST_FAIL = (ADDR_WIDTH-2)'(REG_FIRST_FAIL >> 2);
  localparam logic [ADDR_WIDTH-3:0] W_CONTROL    = (ADDR_WIDTH-2)'(REG_CONTROL >> 2);

  verdict_t state_q, state_d;
  logic [31:0] expected_q, measured_q, meas_merged, rdata;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic access, wr, wr_ctrl, cmd_done, cmd_clear, cmd_abort, clear, cmp_stb;
  logic [COUNT_WIDTH-1:0] test_count, fail_count;
  logic [15:0] first_fail;
  logic last_fail;
  logic unused_adr_lsb;

  assign unused_adr_lsb = ^wb_adr_i[1:0];
  assign word_idx       = wb_adr_i[ADDR_WIDTH-1:2];

  // the access is taken on the edge that raises ack, so side effects are
  // visible during the ack cycle and a repeat strobe is held off one cycle
  assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr        = access & wb_we_i;
  assign wr_ctrl   = wr & (word_idx == W_CONTROL) & wb_sel_i[0];
  assign cmd_done  = wr_ctrl & wb_dat_i[CTRL_DONE];
  assign cmd_clear = wr_ctrl & wb_dat_i[CTRL_CLEAR];
  assign cmd_abort = wr_ctrl & wb_dat_i[CTRL_ABORT];

  assign meas_merged = lane_merge(measured_q, wb_dat_i, wb_sel_i);
  assign cmp_stb     = wr & (word_idx == W_MEASURED) & (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (cmd_abort) begin
          state_d = ST_FAIL;
        end else if (cmd_clear) begin
          clear = 1'b1;
        end else if (cmd_done) begin
          state_d = (test_count == COUNT_WIDTH'(NUMBER_OF_TESTS) && fail_count == '0)
                    ? ST_PASS : ST_FAIL;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (cmd_clear) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (word_idx)
      W_EXPECTED:   rdata = expected_q;
      W_MEASURED:   rdata = measured_q;
      W_STATUS: begin
        rdata[15:0]           = 16'(test_count);
        rdata[STAT_LAST_FAIL] = last_fail;
        rdata[STAT_DONE]      = (state_q != ST_RUN);
        rdata[STAT_PASSED]    = test_passed;
        rdata[STAT_FAILED]    = test_failed;
      end
      W_FAIL_COUNT: rdata = 32'(fail_count);
      W_FIRST_FAIL: rdata = {16'h0000, first_fail};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q     <= ST_RUN;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      expected_q  <= '0;
      measured_q  <= '0;
      test_passed <= 1'b0;
      test_failed <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_ack_o    <= access;
      test_passed <= (state_d == ST_PASS);
      test_failed <= (state_d == ST_FAIL);
      if (access) wb_dat_o <= wb_we_i ? '0 : rdata;
      if (clear) begin
        expected_q <= '0;
        measured_q <= '0;
      end else begin
        if (wr && word_idx == W_EXPECTED) expected_q <= lane_merge(expected_q, wb_dat_i, wb_sel_i);
        if (wr && word_idx == W_MEASURED) measured_q <= meas_merged;
      end
    end
  end

  test_result_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_counter (
    .clk        (wb_clk),
    .rst        (wb_rst),
    .clear      (clear),
    .cmp_stb    (cmp_stb),
    .expected   (expected_q),
    .measured   (meas_merged),
    .test_count (test_count),
    .fail_count (fail_count),
    .first_fail (first_fail),
    .last_fail  (last_fail)
  );

endmodule

// File: tb/tb_wb_test_status_slave.sv
// Bench for wb_test_status_slave: bus stimulus updates a register-level
// model and queues expected responses; a monitor checks each ack.
module tb_wb_test_status_slave;

  localparam int NT = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] dat_r;
  logic        ack, passed, failed;

  wb_test_status_slave #(
    .NUMBER_OF_TESTS(NT),
    .ADDR_WIDTH(8),
    .COUNT_WIDTH(16)
  ) dut (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(dat_r), .wb_ack_o(ack),
    .test_passed(passed), .test_failed(failed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          passed;
    bit          failed;
  } exp_t;

  exp_t  sb[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // reference model: register contents and verdict (0 run, 1 pass, 2 fail)
  logic [31:0] m_exp, m_meas;
  int m_count, m_fail, m_first, m_verdict;
  bit m_last;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    m_exp = 0; m_meas = 0; m_count = 0; m_fail = 0; m_first = 32'hFFFF; m_last = 0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[7:2])
      6'd0: m_exp = merge(m_exp, d, s);
      6'd1: begin
        m_meas = merge(m_meas, d, s);
        if (m_verdict == 0) begin
          m_last = (m_meas != m_exp);
          if (m_last) begin
            if (m_first == 32'hFFFF) m_first = m_count;
            if (m_fail < 65535) m_fail++;
          end
          if (m_count < 65535) m_count++;
        end
      end
      6'd5: if (s[0]) begin
        if (m_verdict == 0) begin
          if (d[2]) m_verdict = 2;
          else if (d[1]) model_clear();
          else if (d[0]) m_verdict = (m_count == NT && m_fail == 0) ? 1 : 2;
        end else if (d[1]) begin
          m_verdict = 0;
          model_clear();
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [15:0] cnt;
    cnt = m_count[15:0];
    case (a[7:2])
      6'd0: return m_exp;
      6'd1: return m_meas;
      6'd2: return {12'h000, m_verdict == 2, m_verdict == 1, m_verdict != 0, m_last, cnt};
      6'd3: return m_fail;
      6'd4: return m_first;
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t make_exp(input bit w, input logic [7:0] a);
    exp_t e;
    e.is_read = !w;
    e.data    = w ? 32'h0 : model_read(a);
    e.passed  = (m_verdict == 1);
    e.failed  = (m_verdict == 2);
    return e;
  endfunction

  task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s, input string nm);
    int lat;
    if (w) model_write(a, d, s);
    sb.push_back(make_exp(w, a));
    name_q.push_back(nm);
    @(posedge clk); #1;
    adr = a; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 8);
    check({nm, " ack_latency"}, lat, 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check({nm, " ack_width"}, {31'b0, ack}, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
    bus(1'b1, a, d, 4'hF, nm);
  endtask

  task automatic rd(input logic [7:0] a, input string nm);
    bus(1'b0, a, 32'h0, 4'hF, nm);
  endtask

  always @(negedge clk) begin
    if (!rst && ack) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with no pending access, expected none");
      end else begin
        exp_t  e;
        string nm;
        e  = sb.pop_front();
        nm = name_q.pop_front();
        if (e.is_read) check({nm, " rdata"}, dat_r, e.data);
        check({nm, " test_passed"}, {31'b0, passed}, {31'b0, e.passed});
        check({nm, " test_failed"}, {31'b0, failed}, {31'b0, e.failed});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 0; cyc = 0; stb = 0;
    m_verdict = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", {31'b0, ack}, 0);
    check("reset dat_o", dat_r, 0);
    check("reset verdicts", {30'b0, passed, failed}, 0);
    rst = 1'b0;

    rd(8'h08, "reset STATUS");
    rd(8'h10, "reset FIRST_FAIL");

    for (int i = 0; i < NT; i++) begin
      wr(8'h00, i, "pass EXP");
      wr(8'h04, i, "pass MEAS");
    end
    wr(8'h14, 32'h1, "pass DONE");
    rd(8'h08, "pass STATUS");

    wr(8'h14, 32'h2, "clear1");
    for (int i = 0; i < NT; i++) begin
      wr(8'h00, i, "fail EXP");
      wr(8'h04, (i == 5) ? 32'hDEADBEEF : i, "fail MEAS");
    end
    wr(8'h14, 32'h1, "fail DONE");
    rd(8'h0C, "fail FAIL_COUNT");
    rd(8'h10, "fail FIRST_FAIL");
    rd(8'h08, "fail STATUS");

    wr(8'h14, 32'h2, "clear2");
    for (int i = 0; i < NT - 1; i++) begin
      wr(8'h00, i, "short EXP");
      wr(8'h04, i, "short MEAS");
    end
    wr(8'h14, 32'h1, "short DONE");
    wr(8'h14, 32'h2, "short CLEAR");
    rd(8'h08, "cleared STATUS");
    rd(8'h10, "cleared FIRST_FAIL");

    wr(8'h00, 32'h11223344, "lane EXP");
    wr(8'h04, 32'h11220000, "lane MEAS full");
    bus(1'b1, 8'h04, 32'hAABBCCDD, 4'b0011, "lane MEAS low");
    rd(8'h04, "lane MEAS read");
    rd(8'h08, "lane STATUS");
    wr(8'h14, 32'h4, "lane ABORT");
    wr(8'h04, 32'h5, "frozen MEAS");
    rd(8'h08, "frozen STATUS");
    rd(8'h04, "frozen MEAS read");
    rd(8'h14, "CONTROL read");

    wr(8'h14, 32'h2, "clear3");
    wr(8'h14, 32'h7, "all-ones CONTROL");
    rd(8'h08, "all-ones STATUS");

    // held strobe: two acks in four cycles
    repeat (2) begin
      sb.push_back(make_exp(1'b0, 8'h08));
      name_q.push_back("burst STATUS");
    end
    @(posedge clk); #1;
    adr = 8'h08; we = 0; sel = 4'hF; cyc = 1; stb = 1;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 0; stb = 0;
    check("burst ack count", acks, 2);
    @(posedge clk); #1;

    // reset during an acked read
    adr = 8'h08; cyc = 1; stb = 1;
    @(posedge clk); #1;
    check("mid ack high", {31'b0, ack}, 1);
    rst = 1'b1;
    #1;
    check("mid ack drop", {31'b0, ack}, 0);
    check("mid verdicts", {30'b0, passed, failed}, 0);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_verdict = 0;
    model_clear();
    rd(8'h08, "post-reset STATUS");
    rd(8'h10, "post-reset FIRST_FAIL");

    for (int r = 0; r < 8; r++) begin
      int n;
      logic [31:0] e, m;
      wr(8'h14, 32'h2, "rnd CLEAR");
      n = $urandom_range(NT - 2, NT + 2);
      for (int i = 0; i < n; i++) begin
        e = $urandom;
        wr(8'h00, e, "rnd EXP");
        m = ((r % 2) == 1 && $urandom_range(0, 3) == 0) ? $urandom : e;
        if ($urandom_range(0, 5) == 0) bus(1'b1, 8'h04, m, 4'($urandom_range(1, 15)), "rnd MEAS sel");
        else wr(8'h04, m, "rnd MEAS");
      end
      wr(8'h18 + 8'(4 * $urandom_range(0, 57)), $urandom, "rnd unmapped wr");
      rd(8'h18 + 8'(4 * $urandom_range(0, 57)), "rnd unmapped rd");
      rd(8'h0C, "rnd FAIL_COUNT");
      rd(8'h10 | 8'($urandom_range(0, 3)), "rnd FIRST_FAIL");
      wr(8'h14, (r < 6) ? 32'h1 : 32'($urandom_range(0, 7)), "rnd CONTROL");
      rd(8'h08, "rnd STATUS");
      wr(8'h04, $urandom, "rnd late MEAS");
      rd(8'h08 | 8'($urandom_range(0, 3)), "rnd late STATUS");
      rd(8'h04, "rnd MEAS read");
    end

    repeat (4) @(posedge clk);
    check("scoreboard empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_test_status_slave.md
Name: wb_test_status_slave

Overview:
- Synthesizable Wishbone classic slave: the hardware-side counterpart of the bench checker tasks.
- Firmware or a DSP bus master writes expected/measured pairs and a completion command. The block compares each pair, counts tests and failures, and drives sticky test_passed/test_failed levels that the bench watches on their rising edge.
- Sits on the wb_dsp system bus beside the DSP core.

Parameters:
- NUMBER_OF_TESTS, 16, test count required for a pass verdict.
- ADDR_WIDTH, 8, width of wb_adr_i (byte address; word-aligned registers).
- COUNT_WIDTH, 16, width of test/fail counters (max 16).

Ports:
- wb_clk  input  1  system clock, all logic on rising edge.
- wb_rst  input  1  reset, asynchronous, active-high.
- wb_adr_i  input  ADDR_WIDTH  byte address.
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte lane enables.
- wb_we_i  input  1  write enable.
- wb_cyc_i  input  1  bus cycle.
- wb_stb_i  input  1  strobe.
- wb_dat_o  output  32  read data, valid with wb_ack_o.
- wb_ack_o  output  1  transfer acknowledge.
- test_passed  output  1  sticky pass verdict.
- test_failed  output  1  sticky fail verdict.

Behaviour:
- Reset: wb_ack_o=0, wb_dat_o=0, test_passed=0, test_failed=0, all registers and counters 0, FSM=RUN.
- Bus handshake:
  - wb_ack_o asserts the cycle after wb_cyc_i&wb_stb_i&!wb_ack_o, for exactly one cycle (one wait state).
  - The register side effect takes place on the ack cycle.
  - Back-to-back strobes are acked every other cycle.
  - Dropping wb_cyc_i before ack aborts with no side effect.
- Register map (word offsets):
  - 0x00 EXPECTED, RW, byte-lane masked.
  - 0x04 MEASURED, RW, byte-lane masked. A write merges lanes, then compares the merged value against EXPECTED the same cycle. A mismatch sets last_fail=1 and increments fail_count. A match sets last_fail=0. test_count increments on every write.
  - 0x08 STATUS, RO: [15:0] test_count, [16] last_fail, [17] done, [18] test_passed, [19] test_failed.
  - 0x0C FAIL_COUNT, RO.
  - 0x10 FIRST_FAIL, RO: test_count index (pre-increment) of the first mismatch. Holds 0xFFFF when there is none; this is also the value after reset and CLEAR.
  - 0x14 CONTROL, WO, write-1 bits:
    - bit0 DONE.
    - bit1 CLEAR.
    - bit2 ABORT.
  - CONTROL priority: ABORT > CLEAR > DONE. Reads of CONTROL return 0.
- Unmapped addresses: acked, read 0, writes ignored. wb_adr_i[1:0] ignored.
- Verdict FSM:
  - RUN, DONE=1: go to PASS if test_count==NUMBER_OF_TESTS and fail_count==0; otherwise go to FAIL.
  - RUN, ABORT=1: go to FAIL.
  - PASS or FAIL, CLEAR=1: go to RUN.
  - CLEAR zeroes counters, last_fail and EXPECTED/MEASURED, and sets FIRST_FAIL to 0xFFFF.
- Outputs and frozen state:
  - test_passed=1 only in PASS; test_failed=1 only in FAIL. Both registered and updated on the ack cycle of the command.
  - In PASS/FAIL, MEASURED writes update the register but do not compare or count.
  - DONE/ABORT in PASS/FAIL are ignored.
  - CLEAR in RUN resets counters and stays in RUN.
- Counter rules: counters saturate at 2^COUNT_WIDTH-1 and do not wrap. A saturated test_count never equals NUMBER_OF_TESTS unless the parameter equals the max.
- Asynchronous reset mid-transfer: ack drops immediately, all state clears. The bus master must retry.

Decomposition:
- Package wb_test_status_pkg:
  - register offset constants;
  - CONTROL bit positions;
  - STATUS bit positions;
  - verdict state enum (RUN, PASS, FAIL);
  - FIRST_FAIL_NONE = 16'hFFFF.
- Sub-module test_result_counter: compare strobe, expected, measured in; test_count, fail_count, first_fail, last_fail out; with saturation and clear.
- Bus decode and the verdict FSM stay in the top module.

Test Plan:
- Reset, then read STATUS -> 0x00000000; FIRST_FAIL -> 0x0000FFFF; test_passed=test_failed=0; each access acked exactly one cycle after strobe.
- 16 pairs EXPECTED=i, MEASURED=i, then CONTROL=0x1 -> STATUS=0x00060010; test_passed rises on the DONE ack cycle; test_failed stays 0.
- 16 pairs with pair 5 MEASURED=0xDEADBEEF vs EXPECTED=5, then DONE -> FAIL_COUNT=1, FIRST_FAIL=5, test_failed=1, STATUS[18]=0.
- 15 matching pairs then DONE -> test_failed=1 (count mismatch). Then CLEAR -> STATUS=0, FIRST_FAIL=0xFFFF, both verdicts 0.
- EXPECTED=0x11223344, then MEASURED write 0xAABBCCDD with sel=4'b0011 after a prior MEASURED=0x11220000 -> merged value 0x1122CCDD mismatches, last_fail=1. ABORT=1 -> test_failed=1. A later MEASURED write leaves test_count unchanged.
- Write CONTROL=0x7 in RUN -> FAIL (ABORT wins). Assert wb_rst mid-strobe -> wb_ack_o drops asynchronously, verdict outputs 0.
